// File: rtl/pc_sequencer_pkg.sv
// Core-wide definitions shared by the fetch sequencer and the branch-target table.
// Sequencer states and default geometry of the PC and the branch table.
package pc_sequencer_pkg;

  localparam int PCW_DEFAULT  = 10;
  localparam int LUTA_DEFAULT = 2;
  localparam int LUT_DEPTH    = 1 << LUTA_DEFAULT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_branch_lut.sv
// Branch-target table: 2^LUTA entries of absolute PCs, one synchronous write port,
// one combinational read port, cleared by the asynchronous active-low reset.
module branch_lut
  import pc_sequencer_pkg::*;
#(
  parameter int PCW  = PCW_DEFAULT,
  parameter int LUTA = LUTA_DEFAULT
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            we,
  input  logic [LUTA-1:0] waddr,
  input  logic [PCW-1:0]  wdata,
  input  logic [LUTA-1:0] raddr,
  output logic [PCW-1:0]  rdata
);

  localparam int DEPTH = 1 << LUTA;

  logic [PCW-1:0] entry_reg [DEPTH];
  logic [DEPTH-1:0] wsel;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wsel
      assign wsel[gi] = we && (waddr == LUTA'(gi));
    end
  endgenerate

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wsel[i]) begin
          entry_reg[i] <= wdata;
        end
      end
    end
  end

  // Read sees the stored value, so a same-cycle write is only visible next cycle.
  assign rdata = entry_reg[raddr];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: IDLE/RUN/DONE handshake with the harness,
// PC advance, stall hold, table-driven branch redirect and end-of-program stop.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PCW  = PCW_DEFAULT,
  parameter int LUTA = LUTA_DEFAULT
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Branch,
  input  logic [LUTA-1:0] How_high,
  input  logic            Cond,
  input  logic            Halt,
  input  logic            Stall,
  input  logic            Lut_we,
  input  logic [LUTA-1:0] Lut_addr,
  input  logic [PCW-1:0]  Lut_data,
  output logic [PCW-1:0]  PC,
  output logic            Running,
  output logic            Done
);

  localparam logic [PCW-1:0] PC_LAST = '1;

  seq_state_t     state_reg, state_next;
  logic [PCW-1:0] pc_reg, pc_next;
  logic [PCW-1:0] target;
  logic           taken;

  branch_lut #(
    .PCW  (PCW),
    .LUTA (LUTA)
  ) u_branch_lut (
    .Clk   (Clk),
    .Reset (Reset),
    .we    (Lut_we),
    .waddr (Lut_addr),
    .wdata (Lut_data),
    .raddr (How_high),
    .rdata (target)
  );

  assign taken = Branch && Cond;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      IDLE: begin
        pc_next = '0;
        if (Start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // Halt outranks stall and branch; the top address stops instead of wrapping.
        if (Halt) begin
          state_next = DONE;
        end else if (Stall) begin
          pc_next = pc_reg;
        end else if (taken) begin
          pc_next = target;
        end else if (pc_reg == PC_LAST) begin
          state_next = DONE;
        end else begin
          pc_next = pc_reg + PCW'(1);
        end
      end
      DONE: begin
        if (Start) begin
          state_next = RUN;
          pc_next    = '0;
        end
      end
      default: begin
        state_next = IDLE;
        pc_next    = '0;
      end
    endcase
  end

  assign PC      = pc_reg;
  assign Running = (state_reg == RUN);
  assign Done    = (state_reg == DONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized checks of pc_sequencer against a cycle-level reference model.
module tb_pc_sequencer;

  localparam int PCW  = 10;
  localparam int LUTA = 2;
  localparam int MAXPC = (1 << PCW) - 1;

  logic            Clk = 1'b0;
  logic            Reset = 1'b0;
  logic            Start = 1'b0;
  logic            Branch = 1'b0;
  logic [LUTA-1:0] How_high = '0;
  logic            Cond = 1'b0;
  logic            Halt = 1'b0;
  logic            Stall = 1'b0;
  logic            Lut_we = 1'b0;
  logic [LUTA-1:0] Lut_addr = '0;
  logic [PCW-1:0]  Lut_data = '0;
  logic [PCW-1:0]  PC;
  logic            Running;
  logic            Done;

  pc_sequencer #(.PCW(PCW), .LUTA(LUTA)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Branch(Branch), .How_high(How_high),
    .Cond(Cond), .Halt(Halt), .Stall(Stall), .Lut_we(Lut_we), .Lut_addr(Lut_addr),
    .Lut_data(Lut_data), .PC(PC), .Running(Running), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Reference model: mode 0 = idle, 1 = running, 2 = finished.
  int m_mode;
  int m_pc;
  int m_tbl [4];
  int n_checks = 0;
  int n_fail   = 0;
  int n_steps  = 0;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".pc"}, int'(PC), m_pc);
    check({tag, ".running"}, int'(Running), (m_mode == 1) ? 1 : 0);
    check({tag, ".done"}, int'(Done), (m_mode == 2) ? 1 : 0);
  endtask

  // One clock: drive inputs after the falling edge, advance model, compare after rise.
  task automatic step(input string tag, input bit st, input bit br, input int hh,
                      input bit cd, input bit hl, input bit sl,
                      input bit we, input int wa, input int wd);
    @(negedge Clk);
    Start = st; Branch = br; How_high = LUTA'(hh); Cond = cd;
    Halt = hl; Stall = sl; Lut_we = we; Lut_addr = LUTA'(wa); Lut_data = PCW'(wd);
    case (m_mode)
      0: if (st) begin m_mode = 1; m_pc = 0; end
      1: begin
        if (hl) m_mode = 2;
        else if (sl) m_pc = m_pc;
        else if (br && cd) m_pc = m_tbl[hh];
        else if (m_pc == MAXPC) m_mode = 2;
        else m_pc = m_pc + 1;
      end
      default: if (st) begin m_mode = 1; m_pc = 0; end
    endcase
    if (we) m_tbl[wa] = wd;
    @(posedge Clk);
    #1;
    n_steps++;
    $display("step %0d %s: st=%0b br=%0b hh=%0d cd=%0b hl=%0b sl=%0b we=%0b[%0d]=0x%0h -> PC=0x%0h run=%0b done=%0b",
             n_steps, tag, st, br, hh, cd, hl, sl, we, wa, wd, PC, Running, Done);
    check_outputs(tag);
  endtask

  task automatic plain(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic write_tbl(input int wa, input int wd);
    step("write", 0, 0, 0, 0, 0, 0, 1, wa, wd);
  endtask

  task automatic jump(input string tag, input int hh);
    step(tag, 0, 1, hh, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 0;
    for (int i = 0; i < 4; i++) m_tbl[i] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge Clk);
    Reset = 1'b1;

    // Idle holds PC at 0 until Start.
    plain("idle");
    plain("idle");
    step("start", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) plain("count");

    // Table branch taken, then not-taken from the same PC.
    write_tbl(2, 'h040);
    write_tbl(3, 7);
    jump("taken_to_0x40", 2);
    jump("back_to_7", 3);
    step("not_taken", 0, 1, 2, 0, 0, 0, 0, 0, 0);

    // Stall three cycles at PC=5, then release.
    write_tbl(0, 5);
    jump("to_5", 0);
    for (int i = 0; i < 3; i++) step("stall", 0, 0, 0, 0, 0, 1, 0, 0, 0);
    plain("release");

    // Halt beats a taken branch at 0x010; DONE holds, Start ignored until given.
    write_tbl(1, 'h010);
    jump("to_0x10", 1);
    step("halt_vs_branch", 0, 1, 2, 1, 1, 0, 0, 0, 0);
    plain("done_hold");
    step("restart", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("start_ignored", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Halt beats stall.
    step("halt_vs_stall", 0, 0, 0, 0, 1, 1, 0, 0, 0);
    step("restart2", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // End of program: top address stops in DONE, no wrap.
    write_tbl(0, 'h3FD);
    jump("to_0x3fd", 0);
    plain("0x3fe");
    plain("0x3ff");
    plain("end_of_program");
    plain("end_hold");
    step("restart3", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Same-cycle write and branch on one index uses the old entry.
    write_tbl(1, 'h020);
    step("wr_and_branch", 0, 1, 1, 1, 0, 0, 1, 1, 'h100);
    jump("new_entry", 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(7) == 0), $urandom_range(1), $urandom_range(3),
           $urandom_range(1), ($urandom_range(15) == 0), ($urandom_range(3) == 0),
           $urandom_range(1), $urandom_range(3), $urandom_range(MAXPC));
    end

    // Asynchronous reset mid-run at PC=0x0A0.
    step("force_run", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    write_tbl(2, 'h0A0);
    jump("to_0xa0", 2);
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    check_outputs("async_reset");
    @(negedge Clk);
    Reset = 1'b1;
    plain("post_reset_idle");
    step("start_after_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    plain("advance");
    for (int i = 0; i < 4; i++) jump("cleared_entry", i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and fetch-sequencing block for the small RISC core; the consumer end of the control decoder's Branch/How_high outputs.
- Holds the PC and a 4-entry branch-target table; advances or redirects the PC every cycle.
- Runs a Start/Done handshake with the test harness.
- Sits between the instruction ROM (driven by PC) and the control decoder (drives Branch, How_high, Halt).

Parameters:
- PCW, 10, program counter width in bits; instruction ROM depth is 2^PCW.
- LUTA, 2, branch-target table index width; matches decoder How_high width; table depth is 2^LUTA.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  harness request to begin program execution; sampled in IDLE and DONE.
- Branch  input  1  decoder branch indication for the current instruction.
- How_high  input  LUTA  decoder branch-table index.
- Cond  input  1  ALU condition flag; a branch is taken only when Branch and Cond are both 1.
- Halt  input  1  decoder halt indication for the current instruction.
- Stall  input  1  hold PC this cycle (multi-cycle memory op).
- Lut_we  input  1  branch-table write enable.
- Lut_addr  input  LUTA  branch-table write index.
- Lut_data  input  PCW  branch-table write data (absolute target PC).
- PC  output  PCW  current instruction address to ROM.
- Running  output  1  1 while in RUN; instruction at PC is valid to execute.
- Done  output  1  1 while in DONE.

Behaviour:
- Reset (Reset=0, async):
  - state=IDLE, PC=0, Running=0, Done=0.
  - All table entries cleared to 0.
- States:
  - IDLE: PC held at 0. Start=1 -> RUN next edge, PC=0.
  - RUN: Running=1. Per edge, in this priority order:
    - Halt=1 -> DONE; PC held.
    - Stall=1 -> PC held.
    - Branch=1 and Cond=1 -> PC = table[How_high].
    - Branch=1 and Cond=0 -> PC+1.
    - Otherwise -> PC+1.
    - Start is ignored in RUN.
  - DONE: Done=1, PC held at the halting/last address. Start=1 -> RUN next edge with PC=0 and Done=0.
- End of program:
  - In RUN, with PC = 2^PCW-1 and no taken branch, no Halt and no Stall: go to DONE with PC held.
  - No wrap to 0.
- Halt with Stall asserted: Halt wins.
- Halt with a taken branch in the same cycle: Halt wins; PC held.
- Branch latency: one cycle. The PC shown in the cycle after the edge is the target; no delay slot.
- Branch-target table:
  - Synchronous write on Clk when Lut_we=1; writable in any state.
  - Read is combinational.
  - Write and taken branch to the same index in the same cycle: the branch uses the pre-write value; the new value is visible from the next cycle.
- Outputs Running and Done decode from state only; they are never both 1.
- Reset asserted mid-RUN: immediate return to IDLE, PC=0, table cleared. Start must be reissued after reset release.
- PC arithmetic is unsigned, PCW bits; the increment carry is discarded; the end-of-program rule above governs the top address.

Decomposition:
- Shared package (core-wide) holds:
  - state enum {IDLE, RUN, DONE};
  - PCW and LUTA default constants;
  - table depth localparam.
- Sub-module branch_lut: 2^LUTA x PCW register table, one write port and one combinational read port, with async active-low clear. It is reused by the assembler-loaded boot path.

Test Plan:
- Reset, then Start pulse; drive no branches for 5 cycles -> PC sequence 0,1,2,3,4,5; Running=1; Done=0.
- Write table[2]=0x040; in RUN at PC=7 drive Branch=1, How_high=2, Cond=1 -> next PC=0x040. Repeat with Cond=0 -> next PC=8.
- At PC=0x010 drive Halt=1 with Branch=1, Cond=1 -> DONE, PC stays 0x010, Done=1. Then Start -> PC=0, Running=1.
- Stall=1 for 3 cycles at PC=5 -> PC stays 5; release -> PC=6. Also Stall and Halt together -> DONE.
- Let PC run to 0x3FF with no halt -> next state DONE, PC=0x3FF. Separately, same-cycle write of table[1]=0x100 and taken branch on index 1 (old value 0x020) -> PC=0x020, and a later branch on index 1 -> PC=0x100.
- Assert Reset low mid-RUN at PC=0x0A0 -> PC=0, IDLE, Running=0, table entries read 0.
